// File: rtl/bcd_seq_counter.sv
// bcd_seq_counter: two-digit BCD up/down counter with prescaled stepping.
// A prescaler divides clk into count steps; each step moves the BCD value
// one position through [MIN_VAL, MAX_VAL] in the up_dn direction, wrapping
// at the range ends. start/stop run or halt stepping; load forces a clamped
// value.
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous reset, active-low
//   start     pulse: enter RUN
//   stop      pulse: enter STOP (wins over start)
//   up_dn     1 = count up, 0 = count down
//   load      pulse: load clamped load_val (wins over a step)
//   load_val  binary load value 0..127
//   tens      BCD tens digit (registered)
//   ones      BCD ones digit (registered)
//   tick      one-cycle pulse with each new step/load value
//   wrap      one-cycle pulse with tick when a step wrapped
//   running   1 while in RUN
module bcd_seq_counter #(
    parameter int unsigned CLK_DIV = 25000000,
    parameter int unsigned MIN_VAL = 0,
    parameter int unsigned MAX_VAL = 14
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       up_dn,
    input  logic       load,
    input  logic [6:0] load_val,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       tick,
    output logic       wrap,
    output logic       running
);

    localparam int unsigned PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
    localparam logic [3:0] MIN_T = 4'(MIN_VAL / 10);
    localparam logic [3:0] MIN_O = 4'(MIN_VAL % 10);
    localparam logic [3:0] MAX_T = 4'(MAX_VAL / 10);
    localparam logic [3:0] MAX_O = 4'(MAX_VAL % 10);
    localparam logic [6:0] MIN_B = 7'(MIN_VAL);
    localparam logic [6:0] MAX_B = 7'(MAX_VAL);

    // Elaboration-time parameter sanity check
    if (CLK_DIV < 2 || MIN_VAL > MAX_VAL || MAX_VAL > 99) begin : g_param_check
        $error("bcd_seq_counter: illegal CLK_DIV/MIN_VAL/MAX_VAL");
    end

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [PW-1:0] presc;
    logic [PW-1:0] presc_next;
    logic          step_c;
    logic [3:0]    step_tens;
    logic [3:0]    step_ones;
    logic          step_wrap;
    logic [6:0]    clamped;
    logic [6:0]    rem;
    logic [3:0]    ld_tens;
    logic [3:0]    ld_ones;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_STOP;
        end else begin
            state <= state_next;
        end
    end

    // Next state, step enable and prescaler update
    always_comb begin
        state_next = state;
        step_c     = 1'b0;
        presc_next = '0;
        case (state)
            ST_STOP: begin
                if (start) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_next = ST_STOP;
                end else begin
                    step_c = (presc == PRE_LAST);
                    if (!step_c && !load) begin
                        presc_next = presc + PW'(1);
                    end
                end
            end
            default: state_next = ST_STOP;
        endcase
    end

    // Next BCD value for a step, with wrap at the range ends
    always_comb begin
        step_tens = tens;
        step_ones = ones;
        step_wrap = 1'b0;
        if (up_dn) begin
            if (tens == MAX_T && ones == MAX_O) begin
                step_tens = MIN_T;
                step_ones = MIN_O;
                step_wrap = 1'b1;
            end else if (ones == 4'd9) begin
                step_ones = 4'd0;
                step_tens = tens + 4'd1;
            end else begin
                step_ones = ones + 4'd1;
            end
        end else begin
            if (tens == MIN_T && ones == MIN_O) begin
                step_tens = MAX_T;
                step_ones = MAX_O;
                step_wrap = 1'b1;
            end else if (ones == 4'd0) begin
                step_ones = 4'd9;
                step_tens = tens - 4'd1;
            end else begin
                step_ones = ones - 4'd1;
            end
        end
    end

    // Clamp load_val, then binary-to-BCD by weighted compare/subtract (80/40/20/10)
    always_comb begin
        clamped = load_val;
        if (load_val <= MIN_B) begin
            clamped = MIN_B;
        end else if (load_val >= MAX_B) begin
            clamped = MAX_B;
        end
        rem     = clamped;
        ld_tens = 4'd0;
        if (rem >= 7'd80) begin
            rem     = rem - 7'd80;
            ld_tens = ld_tens | 4'd8;
        end
        if (rem >= 7'd40) begin
            rem     = rem - 7'd40;
            ld_tens = ld_tens | 4'd4;
        end
        if (rem >= 7'd20) begin
            rem     = rem - 7'd20;
            ld_tens = ld_tens | 4'd2;
        end
        if (rem >= 7'd10) begin
            rem     = rem - 7'd10;
            ld_tens = ld_tens | 4'd1;
        end
        ld_ones = rem[3:0];
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc   <= '0;
            tens    <= MIN_T;
            ones    <= MIN_O;
            tick    <= 1'b0;
            wrap    <= 1'b0;
            running <= 1'b0;
        end else begin
            presc   <= presc_next;
            running <= (state_next == ST_RUN);
            tick    <= load | step_c;
            wrap    <= !load && step_c && step_wrap;
            if (load) begin
                tens <= ld_tens;
                ones <= ld_ones;
            end else if (step_c) begin
                tens <= step_tens;
                ones <= step_ones;
            end
        end
    end

endmodule

// File: tb/tb_bcd_seq_counter.sv
// Bench for bcd_seq_counter: a binary-value reference model checked every
// cycle, plus literal checks of key points; a second instance with
// MIN_VAL=5 covers low-side load clamping.
module tb_bcd_seq_counter;

    localparam int DIV  = 4;
    localparam int MINV = 0;
    localparam int MAXV = 14;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, stop, up_dn, load;
    logic [6:0] load_val;
    logic [3:0] tens, ones;
    logic       tick, wrap, running;

    logic       load2;
    logic [6:0] load_val2;
    logic [3:0] tens2, ones2;
    logic       tick2, wrap2, running2;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // reference model state
    int m_val, m_phase;
    bit m_run, m_tick, m_wrap;

    always #5 clk = ~clk;

    bcd_seq_counter #(.CLK_DIV(DIV), .MIN_VAL(MINV), .MAX_VAL(MAXV)) u_dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .up_dn(up_dn),
        .load(load), .load_val(load_val), .tens(tens), .ones(ones),
        .tick(tick), .wrap(wrap), .running(running)
    );

    bcd_seq_counter #(.CLK_DIV(DIV), .MIN_VAL(5), .MAX_VAL(14)) u_dut5 (
        .clk(clk), .rst(rst), .start(1'b0), .stop(1'b0), .up_dn(1'b1),
        .load(load2), .load_val(load_val2), .tens(tens2), .ones(ones2),
        .tick(tick2), .wrap(wrap2), .running(running2)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: binary value, step every DIV cycles in RUN
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_run = 1'b0; m_phase = 0; m_val = MINV; m_tick = 1'b0; m_wrap = 1'b0;
        end else begin
            bit was_run, do_step;
            was_run = m_run;
            do_step = was_run && !stop && (m_phase == DIV - 1);
            m_tick  = 1'b0;
            m_wrap  = 1'b0;
            if (!was_run || stop || load || do_step) m_phase = 0;
            else m_phase = m_phase + 1;
            if (was_run && stop) m_run = 1'b0;
            else if (!was_run && start) m_run = 1'b1;
            if (load) begin
                m_val  = (int'(load_val) < MINV) ? MINV :
                         (int'(load_val) > MAXV) ? MAXV : int'(load_val);
                m_tick = 1'b1;
            end else if (do_step) begin
                m_tick = 1'b1;
                if (up_dn) begin
                    if (m_val == MAXV) begin m_val = MINV; m_wrap = 1'b1; end
                    else m_val = m_val + 1;
                end else begin
                    if (m_val == MINV) begin m_val = MAXV; m_wrap = 1'b1; end
                    else m_val = m_val - 1;
                end
            end
        end
    end

    // Per-cycle compare against the model
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            check("cyc_tens", int'(tens), m_val / 10);
            check("cyc_ones", int'(ones), m_val % 10);
            check("cyc_tick", int'(tick), int'(m_tick));
            check("cyc_wrap", int'(wrap), int'(m_wrap));
            check("cyc_running", int'(running), int'(m_run));
        end
    end

    initial begin
        rst = 1'b0; start = 1'b0; stop = 1'b0; up_dn = 1'b1; load = 1'b0;
        load_val = '0; load2 = 1'b0; load_val2 = '0;
        repeat (3) @(negedge clk);
        check("rst_tens", int'(tens), 0);
        check("rst_ones", int'(ones), 0);
        check("rst_running", int'(running), 0);
        check("rst_tick", int'(tick), 0);
        check("rst_wrap", int'(wrap), 0);
        check("rst2_ones", int'(ones2), 5);
        rst = 1'b1;
        chk_en = 1'b1;

        // count up: first step 4 cycles after start, wrap on 14->00
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(posedge clk); #1;
        check("first_tick", int'(tick), 1);
        check("first_val", int'(tens) * 10 + int'(ones), 1);
        repeat (56) @(posedge clk); #1;
        check("up_wrap", int'(wrap), 1);
        check("up_wrap_val", int'(tens) * 10 + int'(ones), 0);

        // count down: 00->14 wraps, borrow 10->09
        @(negedge clk); up_dn = 1'b0;
        repeat (4) @(posedge clk); #1;
        check("dn_wrap", int'(wrap), 1);
        check("dn_wrap_val", int'(tens) * 10 + int'(ones), 14);
        repeat (20) @(posedge clk); #1;
        check("dn_borrow_tens", int'(tens), 0);
        check("dn_borrow_ones", int'(ones), 9);

        // start+stop together in RUN: stop wins, value held
        @(negedge clk); start = 1'b1; stop = 1'b1;
        @(negedge clk); start = 1'b0; stop = 1'b0;
        check("stop_running", int'(running), 0);
        repeat (12) @(negedge clk);
        check("held_val", int'(tens) * 10 + int'(ones), 9);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(posedge clk); #1;
        check("resume_val", int'(tens) * 10 + int'(ones), 8);
        @(negedge clk); stop = 1'b1;
        @(negedge clk); stop = 1'b0;

        // loads in STOP
        load_val = 7'd120; load = 1'b1;
        @(negedge clk); load = 1'b0;
        check("ld120_val", int'(tens) * 10 + int'(ones), 14);
        check("ld120_tick", int'(tick), 1);
        check("ld120_wrap", int'(wrap), 0);
        check("ld120_running", int'(running), 0);
        load_val = 7'd7; load = 1'b1;
        @(negedge clk); load = 1'b0;
        check("ld7_tens", int'(tens), 0);
        check("ld7_ones", int'(ones), 7);

        // load coincident with a step at 03 going up
        load_val = 7'd3; load = 1'b1;
        @(negedge clk); load = 1'b0; up_dn = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); load_val = 7'd10; load = 1'b1;
        @(negedge clk); load = 1'b0;
        check("ldstep_val", int'(tens) * 10 + int'(ones), 10);
        check("ldstep_wrap", int'(wrap), 0);
        repeat (4) @(posedge clk); #1;
        check("ldstep_next", int'(tens) * 10 + int'(ones), 11);
        check("ldstep_next_tick", int'(tick), 1);

        // reset mid-count at 12
        repeat (4) @(posedge clk); #1;
        check("pre_rst_val", int'(tens) * 10 + int'(ones), 12);
        @(negedge clk); rst = 1'b0;
        #1;
        check("midrst_val", int'(tens) * 10 + int'(ones), 0);
        check("midrst_running", int'(running), 0);
        check("midrst_tick", int'(tick), 0);
        @(negedge clk); rst = 1'b1;
        repeat (10) @(negedge clk);

        // low-side clamp on MIN_VAL=5 instance
        load_val2 = 7'd2; load2 = 1'b1;
        @(negedge clk); load2 = 1'b0;
        check("min5_tens", int'(tens2), 0);
        check("min5_ones", int'(ones2), 5);
        check("min5_tick", int'(tick2), 1);
        load_val2 = 7'd99; load2 = 1'b1;
        @(negedge clk); load2 = 1'b0;
        check("min5_hi_val", int'(tens2) * 10 + int'(ones2), 14);
        check("min5_running", int'(running2), 0);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_seq_counter.md
Name: bcd_seq_counter

Overview:
Upstream count source for the two-digit seven-segment display path. It divides the board clock into a count tick and steps a two-digit BCD value through a parameterised range, in either direction, with wrap-around. It drives registered tens/ones digits plus update and wrap strobes into the downstream segment decoders. Start, stop and load controls are provided for lab exercises.

Parameters:
CLK_DIV, 25000000, board clocks per count step (≥2); simulation uses 4
MIN_VAL, 0, lowest count value, binary 0..99
MAX_VAL, 14, highest count value, binary MIN_VAL..99

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
start  in  1  single-cycle pulse: enter RUN
stop  in  1  single-cycle pulse: enter STOP
up_dn  in  1  1 = count up, 0 = count down; sampled at each step
load  in  1  single-cycle pulse: load load_val
load_val  in  7  binary value to load, 0..127
tens  out  4  BCD tens digit, 0..9
ones  out  4  BCD ones digit, 0..9
tick  out  1  one-cycle pulse, high the cycle after tens/ones change by a step or load
wrap  out  1  one-cycle pulse, coincident with tick when a step wrapped
running  out  1  1 in RUN state

Behaviour:
- Reset (rst=0, asynchronous): state=STOP, prescaler=0, tens/ones=BCD(MIN_VAL), tick=0, wrap=0, running=0. Release is synchronous to clk.
- All outputs are registered. There is no combinational path from inputs to outputs.
- FSM states:
  - STOP: running=0, prescaler held at 0. start → RUN.
  - RUN: running=1. stop → STOP. Stop wins over start when both are high in the same cycle.
  - A stop pulse clears the prescaler immediately.
- Prescaler:
  - In RUN it counts 0..CLK_DIV-1.
  - On the cycle it equals CLK_DIV-1, a step occurs and the prescaler returns to 0.
  - The first step therefore lands CLK_DIV cycles after entering RUN.
- Step, up (up_dn=1):
  - If value==MAX_VAL: value←MIN_VAL, wrap=1.
  - Otherwise: ones+1; if ones==9 then ones←0 and tens+1.
- Step, down (up_dn=0):
  - If value==MIN_VAL: value←MAX_VAL, wrap=1.
  - Otherwise: ones-1; if ones==0 then ones←9 and tens-1.
- Range comparisons are done on the BCD pair against BCD constants derived from the parameters at elaboration.
- Load:
  - load has priority over a step in the same cycle; that step is discarded.
  - load_val is clamped: values below MIN_VAL become MIN_VAL, values above MAX_VAL become MAX_VAL.
  - The clamped value is converted to BCD (tens = v/10, ones = v%10) using a compare/subtract conversion. Divider IP is not used.
  - Load resets the prescaler to 0, pulses tick with wrap=0, and does not change the FSM state.
  - Load works in both STOP and RUN.
- tick/wrap are high for exactly one cycle per event and are never high in STOP except on a load.
- Simultaneous stop and load: both take effect (state→STOP, value loaded, tick=1).
- Digit values 10..15 never appear on tens/ones.
- Reset asserted mid-count: outputs return to reset values immediately. No tick is generated on reset release.
- Illegal parameters (MIN_VAL>MAX_VAL, MAX_VAL>99, CLK_DIV<2) are flagged by an elaboration-time assertion.
- With MIN_VAL==MAX_VAL, every step produces wrap=1 and the value is unchanged.

Test Plan:
- Reset then release, CLK_DIV=4, MIN=0, MAX=14; pulse start, up_dn=1 → tens/ones step 00,01,...,09,10,...,14,00. One tick every 4 cycles; wrap=1 only on 14→00; first tick 4 cycles after start.
- up_dn=0 from 00 with MIN=0, MAX=14 → 14,13,...,10,09. wrap=1 on 00→14; BCD borrow 10→09 is correct.
- Load load_val=120 in STOP → value 14 (clamped), tick=1, wrap=0, running stays 0. Load 7 → 07. Load with MIN=5 and load_val=2 → 05.
- load and a step in the same cycle while at 03, up → value = loaded value, the step is lost, and the next step comes 4 cycles later.
- start and stop high together in RUN → STOP, running=0, no further ticks. A later start resumes from the held value.
- rst pulled low for 1 cycle mid-count at value 12 → immediately 00 (MIN), running=0, tick=0. No spurious tick after release.
